panel_refresh_sequencer: RTL and testbench
==========================================

Name: panel_refresh_sequencer

Overview:
- Drives the three 16-bit PISO panel shift registers (red/green/blue) and the LED driver chips they feed.
- Issues load, shift, serial-clock, latch, blank and mode strobes in the required order.
- Multiplexes cube layers (rows) and tells the future LED-value RAM which layer to present.
- Reloads brightness (dot-correction) data after reset and on request.

Parameters:
- WIDTH, 16: bits per shift-register frame. Sets the shift-pulse count per load.
- CLK_DIV, 2: clk cycles per serial_clk half-period. Must be at least 1.
- LATCH_CYCLES, 2: width of the latch pulse, in clk cycles. Must be at least 1.
- DISPLAY_CYCLES, 256: extra hold time per layer after the latch. Must be at least 1.
- NUM_LAYERS, 16: number of multiplexed layers. Must be at least 2.
- LAYER_BITS, 4: width of the layer indices. Must equal $clog2(NUM_LAYERS).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run refresh; sampled only in IDLE and at the end of DISPLAY.
- brightness_req  in  1  single-cycle request to reload brightness; sets a sticky flag.
- load_led_vals  out  1  one-cycle pulse; parallel-loads LED values into the PISOs.
- load_brightness  out  1  one-cycle pulse; parallel-loads brightness into the PISOs.
- shift  out  1  one-cycle pulse; advances the PISOs by one bit.
- serial_clk  out  1  shift clock to the driver chips.
- latch  out  1  driver-chip latch strobe.
- mode_select  out  1  1 = brightness/dot-correction register, 0 = greyscale register.
- blank  out  1  1 = driver outputs off.
- shift_layer  out  LAYER_BITS  RAM layer address for the data being loaded/shifted.
- active_layer  out  LAYER_BITS  layer transistor currently driven.
- frame_done  out  1  one-cycle pulse when the last layer finishes DISPLAY.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all pulse outputs 0, serial_clk 0, latch 0, mode_select 0, blank 1, both layer indices 0, frame_done 0, busy 0. State is IDLE and the brightness-pending flag is set to 1.
- Reset mid-operation: state goes to IDLE on the next edge and all outputs take their reset values. No partial latch pulse is extended.
- brightness_req sets the pending flag on any cycle. The flag clears on entry to BR_LOAD. A request arriving in the same cycle as that clear keeps the flag set.
- States and transitions:
  - IDLE: blank=1. If enable is high, go to BR_LOAD when pending, else to D_LOAD.
  - BR_LOAD (1 cycle): load_brightness=1, mode_select=1. Next state BR_SHIFT.
  - BR_SHIFT: mode_select=1; shift engine runs (see below). Next state BR_LATCH.
  - BR_LATCH (LATCH_CYCLES cycles): latch=1, mode_select=1, blank=1. Next state D_LOAD.
  - D_LOAD (1 cycle): load_led_vals=1; shift_layer is stable during this cycle. Next state D_SHIFT.
  - D_SHIFT: shift engine runs. Next state BLANK.
  - BLANK (1 cycle): blank=1. Next state D_LATCH.
  - D_LATCH (LATCH_CYCLES cycles): latch=1, blank=1. Next state SWITCH.
  - SWITCH (1 cycle): blank=1. active_layer takes shift_layer; shift_layer increments and wraps from NUM_LAYERS-1 to 0. Next state DISPLAY.
  - DISPLAY (DISPLAY_CYCLES cycles): blank=0. On its last cycle, frame_done=1 if active_layer==NUM_LAYERS-1. Then go to IDLE if enable is low, else BR_LOAD if pending, else D_LOAD.
- Shift engine:
  - A bit counter runs 0..WIDTH-1; a phase counter runs 0..2*CLK_DIV-1.
  - serial_clk=1 while phase >= CLK_DIV.
  - shift=1 when phase == 2*CLK_DIV-1; phase then wraps and the bit counter increments.
  - The engine exits after the shift pulse of bit WIDTH-1.
  - Total duration is WIDTH*2*CLK_DIV cycles, giving exactly WIDTH serial_clk rising edges and WIDTH shift pulses. serial_clk is 0 on exit.
- Blanking:
  - blank is 0 from the start of DISPLAY through the following D_LOAD/D_SHIFT, or the following BR_LOAD/BR_SHIFT. The previous layer stays lit while the next layer shifts.
  - blank is 1 during BLANK, all latch states, SWITCH and IDLE.
- mode_select changes only on entry to BR_LOAD (to 1) or to D_LOAD (to 0). It never changes while latch=1.
- load_led_vals, load_brightness and shift are never high in the same cycle.
- Counters: the phase counter is sized for 2*CLK_DIV, the bit counter for WIDTH, and the hold counter for max(LATCH_CYCLES, DISPLAY_CYCLES). No counter overflows.
- Layer period with defaults: 1 + 64 + 1 + 2 + 1 + 256 = 325 cycles (D_LOAD to D_LOAD).

Test Plan:
- Reset, then enable=1 -> BR_LOAD at cycle 1 after IDLE; 16 shift pulses 4 cycles apart with mode_select=1; latch high for 2 cycles; then load_led_vals with shift_layer=0.
- Steady refresh, defaults -> load_led_vals every 325 cycles; active_layer sequence 0,1,…,15,0; frame_done once per 16 layers, on the last DISPLAY cycle of layer 15; blank=1 for exactly 4 cycles per layer.
- Serial timing: count serial_clk rising edges between load_led_vals and latch -> exactly 16 edges; each shift pulse coincides with the last high cycle; serial_clk is 0 during latch.
- brightness_req pulsed mid-DISPLAY -> the next sequence after DISPLAY is BR_LOAD, then D_LOAD. A second request during BR_SHIFT -> one further brightness reload after the following DISPLAY.
- enable dropped during D_SHIFT -> the sequence finishes DISPLAY, enters IDLE with blank=1 and busy=0. Re-enable -> resumes at D_LOAD with shift_layer continuing from where it stopped.
- reset asserted during D_LATCH -> next cycle latch=0, blank=1, both layer indices 0. After release, the brightness reload occurs first.

Source files
------------

// File: rtl/panel_refresh_sequencer.sv
// Panel refresh sequencer: drives the RGB PISO shift registers and the LED
// driver chips (load, shift, serial clock, latch, blank, mode), multiplexes
// cube layers and reloads dot-correction data after reset or on request.
module panel_refresh_sequencer #(
   parameter int WIDTH          = 16,
   parameter int CLK_DIV        = 2,
   parameter int LATCH_CYCLES   = 2,
   parameter int DISPLAY_CYCLES = 256,
   parameter int NUM_LAYERS     = 16,
   parameter int LAYER_BITS     = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  brightness_req,
   output logic                  load_led_vals,
   output logic                  load_brightness,
   output logic                  shift,
   output logic                  serial_clk,
   output logic                  latch,
   output logic                  mode_select,
   output logic                  blank,
   output logic [LAYER_BITS-1:0] shift_layer,
   output logic [LAYER_BITS-1:0] active_layer,
   output logic                  frame_done,
   output logic                  busy
);

   localparam int PHASE_W  = $clog2(2 * CLK_DIV);
   localparam int BIT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int HOLD_MAX = (LATCH_CYCLES > DISPLAY_CYCLES) ? LATCH_CYCLES : DISPLAY_CYCLES;
   localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

   localparam logic [PHASE_W-1:0]    PHASE_LAST   = PHASE_W'(2 * CLK_DIV - 1);
   localparam logic [PHASE_W-1:0]    PHASE_HIGH   = PHASE_W'(CLK_DIV);
   localparam logic [BIT_W-1:0]      BIT_LAST     = BIT_W'(WIDTH - 1);
   localparam logic [HOLD_W-1:0]     LATCH_LAST   = HOLD_W'(LATCH_CYCLES - 1);
   localparam logic [HOLD_W-1:0]     DISPLAY_LAST = HOLD_W'(DISPLAY_CYCLES - 1);
   localparam logic [LAYER_BITS-1:0] LAYER_LAST   = LAYER_BITS'(NUM_LAYERS - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_BR_LOAD,
      S_BR_SHIFT,
      S_BR_LATCH,
      S_D_LOAD,
      S_D_SHIFT,
      S_BLANK,
      S_D_LATCH,
      S_SWITCH,
      S_DISPLAY
   } state_t;

   state_t                  state_reg, state_next;
   logic [PHASE_W-1:0]      phase_reg, phase_next;
   logic [BIT_W-1:0]        bit_reg, bit_next;
   logic [HOLD_W-1:0]       hold_reg, hold_next;
   logic                    pending_reg, pending_next;
   // Set while the previous layer is still lit, so the next shift keeps it on.
   logic                    lit_reg, lit_next;
   logic [LAYER_BITS-1:0]   shift_layer_reg, shift_layer_next;
   logic [LAYER_BITS-1:0]   active_layer_reg, active_layer_next;

   logic in_shift;
   logic shift_pulse;
   logic shift_done;
   logic latch_done;
   logic display_done;

   assign in_shift     = (state_reg == S_BR_SHIFT) || (state_reg == S_D_SHIFT);
   assign shift_pulse  = in_shift && (phase_reg == PHASE_LAST);
   assign shift_done   = shift_pulse && (bit_reg == BIT_LAST);
   assign latch_done   = (hold_reg == LATCH_LAST);
   assign display_done = (hold_reg == DISPLAY_LAST);

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= S_IDLE;
         phase_reg        <= '0;
         bit_reg          <= '0;
         hold_reg         <= '0;
         pending_reg      <= 1'b1;
         lit_reg          <= 1'b0;
         shift_layer_reg  <= '0;
         active_layer_reg <= '0;
      end else begin
         state_reg        <= state_next;
         phase_reg        <= phase_next;
         bit_reg          <= bit_next;
         hold_reg         <= hold_next;
         pending_reg      <= pending_next;
         lit_reg          <= lit_next;
         shift_layer_reg  <= shift_layer_next;
         active_layer_reg <= active_layer_next;
      end
   end

   // Next-state decode of the refresh sequence.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (enable) state_next = pending_reg ? S_BR_LOAD : S_D_LOAD;
         end
         S_BR_LOAD:  state_next = S_BR_SHIFT;
         S_BR_SHIFT: if (shift_done) state_next = S_BR_LATCH;
         S_BR_LATCH: if (latch_done) state_next = S_D_LOAD;
         S_D_LOAD:   state_next = S_D_SHIFT;
         S_D_SHIFT:  if (shift_done) state_next = S_BLANK;
         S_BLANK:    state_next = S_D_LATCH;
         S_D_LATCH:  if (latch_done) state_next = S_SWITCH;
         S_SWITCH:   state_next = S_DISPLAY;
         S_DISPLAY: begin
            if (display_done) begin
               if (!enable)         state_next = S_IDLE;
               else if (pending_reg) state_next = S_BR_LOAD;
               else                  state_next = S_D_LOAD;
            end
         end
         default:    state_next = S_IDLE;
      endcase
   end

   // Counters, brightness-pending flag, lit tracking and layer indices.
   always_comb begin
      phase_next        = '0;
      bit_next          = '0;
      hold_next         = '0;
      lit_next          = 1'b0;
      shift_layer_next  = shift_layer_reg;
      active_layer_next = active_layer_reg;

      if (in_shift) begin
         phase_next = (phase_reg == PHASE_LAST) ? '0 : phase_reg + 1'b1;
         if (shift_pulse) bit_next = (bit_reg == BIT_LAST) ? '0 : bit_reg + 1'b1;
         else             bit_next = bit_reg;
      end

      if (state_reg == S_BR_LATCH || state_reg == S_D_LATCH)
         hold_next = latch_done ? '0 : hold_reg + 1'b1;
      else if (state_reg == S_DISPLAY)
         hold_next = display_done ? '0 : hold_reg + 1'b1;

      // A request in the same cycle as the clear wins, so it is never lost.
      pending_next = brightness_req | (pending_reg & (state_next != S_BR_LOAD));

      case (state_reg)
         S_DISPLAY:                                  lit_next = 1'b1;
         S_BR_LOAD, S_BR_SHIFT, S_D_LOAD, S_D_SHIFT: lit_next = lit_reg;
         default:                                    lit_next = 1'b0;
      endcase

      if (state_reg == S_SWITCH) begin
         active_layer_next = shift_layer_reg;
         shift_layer_next  = (shift_layer_reg == LAYER_LAST) ? '0 : shift_layer_reg + 1'b1;
      end
   end

   // Output decode from the current state and counters.
   always_comb begin
      load_led_vals   = 1'b0;
      load_brightness = 1'b0;
      latch           = 1'b0;
      mode_select     = 1'b0;
      blank           = 1'b1;
      frame_done      = 1'b0;
      shift           = shift_pulse;
      serial_clk      = in_shift && (phase_reg >= PHASE_HIGH);
      busy            = (state_reg != S_IDLE);
      shift_layer     = shift_layer_reg;
      active_layer    = active_layer_reg;
      case (state_reg)
         S_BR_LOAD: begin
            load_brightness = 1'b1;
            mode_select     = 1'b1;
            blank           = ~lit_reg;
         end
         S_BR_SHIFT: begin
            mode_select = 1'b1;
            blank       = ~lit_reg;
         end
         S_BR_LATCH: begin
            latch       = 1'b1;
            mode_select = 1'b1;
         end
         S_D_LOAD: begin
            load_led_vals = 1'b1;
            blank         = ~lit_reg;
         end
         S_D_SHIFT:  blank = ~lit_reg;
         S_D_LATCH:  latch = 1'b1;
         S_DISPLAY: begin
            blank      = 1'b0;
            frame_done = display_done && (active_layer_reg == LAYER_LAST);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_panel_refresh_sequencer.sv
// Bench for panel_refresh_sequencer: cycle-by-cycle segment vectors with
// hand-derived expectations, plus hand-built multi-cycle corner sequences.
module tb_panel_refresh_sequencer;
   localparam int WIDTH   = 16;
   localparam int CLK_DIV = 2;
   localparam int LATCH   = 2;
   localparam int DISP    = 256;
   localparam int NL      = 16;
   localparam int SH      = WIDTH * 2 * CLK_DIV;

   logic       clk = 1'b0;
   logic       reset, enable, brightness_req;
   logic       load_led_vals, load_brightness, shift, serial_clk, latch;
   logic       mode_select, blank, frame_done, busy;
   logic [3:0] shift_layer, active_layer;

   int n_checks = 0;
   int n_fails  = 0;
   int fd_seen  = 0;

   panel_refresh_sequencer #(
      .WIDTH(WIDTH), .CLK_DIV(CLK_DIV), .LATCH_CYCLES(LATCH),
      .DISPLAY_CYCLES(DISP), .NUM_LAYERS(NL), .LAYER_BITS(4)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .brightness_req(brightness_req),
      .load_led_vals(load_led_vals), .load_brightness(load_brightness),
      .shift(shift), .serial_clk(serial_clk), .latch(latch),
      .mode_select(mode_select), .blank(blank), .shift_layer(shift_layer),
      .active_layer(active_layer), .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   // One segment = a run of cycles in one state with constant expectations;
   // shift/serial_clk follow the engine pattern when eng is set.
   typedef struct {
      string      name;
      int         cycles;
      bit         rst;
      bit         en;
      int         en_at;
      int         req_at;
      bit         ld, lb, eng, lat, md, bl, bz, fd_last;
      logic [3:0] sl, al;
   } seg_t;

   function automatic seg_t seg(input string name, input int cycles,
                                input bit ld, input bit lb, input bit eng,
                                input bit lat, input bit md, input bit bl,
                                input bit bz, input bit fd_last,
                                input int sl, input int al);
      seg_t s;
      s.name = name; s.cycles = cycles; s.rst = 1'b0; s.en = 1'b1;
      s.en_at = -1; s.req_at = -1;
      s.ld = ld; s.lb = lb; s.eng = eng; s.lat = lat; s.md = md; s.bl = bl;
      s.bz = bz; s.fd_last = fd_last; s.sl = 4'(sl); s.al = 4'(al);
      return s;
   endfunction

   function automatic logic [16:0] pack(input logic ld, input logic lb, input logic sh,
                                        input logic sc, input logic lat, input logic md,
                                        input logic bl, input logic fd, input logic bz,
                                        input logic [3:0] sl, input logic [3:0] al);
      return {ld, lb, sh, sc, lat, md, bl, fd, bz, sl, al};
   endfunction

   task automatic run_seg(input seg_t s);
      logic [16:0] exp_v, act_v;
      logic        prev_sc;
      int          rises;
      int          ph;
      prev_sc = 1'b0;
      rises   = 0;
      for (int k = 0; k < s.cycles; k++) begin
         reset          = s.rst;
         if (k == s.en_at) enable = s.en;
         brightness_req = (k == s.req_at);
         ph = k % (2 * CLK_DIV);
         exp_v = pack(s.ld, s.lb, s.eng && (ph == 2 * CLK_DIV - 1), s.eng && (ph >= CLK_DIV),
                      s.lat, s.md, s.bl, s.fd_last && (k == s.cycles - 1), s.bz, s.sl, s.al);
         act_v = pack(load_led_vals, load_brightness, shift, serial_clk, latch,
                      mode_select, blank, frame_done, busy, shift_layer, active_layer);
         n_checks++;
         if (act_v !== exp_v) begin
            n_fails++;
            $display("FAIL %s[%0d]: got %h expected %h (ld lb sh sc lat md bl fd bz sl al)",
                     s.name, k, act_v, exp_v);
         end
         if (frame_done === 1'b1) fd_seen++;
         if (serial_clk === 1'b1 && prev_sc === 1'b0) rises++;
         prev_sc = serial_clk;
         @(posedge clk);
         #1;
      end
      brightness_req = 1'b0;
      if (s.eng) begin
         n_checks++;
         if (rises != WIDTH) begin
            n_fails++;
            $display("FAIL %s serial_clk rises: got %0d expected %0d", s.name, rises, WIDTH);
         end
      end
   endtask

   task automatic do_br(input bit lit, input int sl, input int al, input int shift_req);
      seg_t s;
      run_seg(seg("br_load", 1, 0, 1, 0, 0, 1, ~lit, 1, 0, sl, al));
      s = seg("br_shift", SH, 0, 0, 1, 0, 1, ~lit, 1, 0, sl, al);
      s.req_at = shift_req;
      run_seg(s);
      run_seg(seg("br_latch", LATCH, 0, 0, 0, 1, 1, 1, 1, 0, sl, al));
   endtask

   task automatic do_layer(input int l, input int al_before, input bit lit,
                           input int disp_req, input int drop_at);
      seg_t s;
      run_seg(seg("d_load", 1, 1, 0, 0, 0, 0, ~lit, 1, 0, l, al_before));
      s = seg("d_shift", SH, 0, 0, 1, 0, 0, ~lit, 1, 0, l, al_before);
      if (drop_at >= 0) begin
         s.en = 1'b0;
         s.en_at = drop_at;
      end
      run_seg(s);
      run_seg(seg("blank", 1, 0, 0, 0, 0, 0, 1, 1, 0, l, al_before));
      run_seg(seg("d_latch", LATCH, 0, 0, 0, 1, 0, 1, 1, 0, l, al_before));
      run_seg(seg("switch", 1, 0, 0, 0, 0, 0, 1, 1, 0, l, al_before));
      s = seg("display", DISP, 0, 0, 0, 0, 0, 0, 1, (l == NL - 1), (l + 1) % NL, l);
      s.req_at = disp_req;
      run_seg(s);
   endtask

   seg_t tbl[12];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      seg_t s;
      reset = 1'b1; enable = 1'b0; brightness_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset, idle, first enable: brightness reload then layer 0.
      tbl[0]  = seg("reset",    3,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[0].rst = 1'b1; tbl[0].en = 1'b0; tbl[0].en_at = 0;
      tbl[1]  = seg("idle",     2,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[1].en = 1'b0; tbl[1].en_at = 0;
      tbl[2]  = seg("idle_en",  1,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[2].en_at = 0;
      tbl[3]  = seg("br_load",  1,  0, 1, 0, 0, 1, 1, 1, 0, 0, 0);
      tbl[4]  = seg("br_shift", SH, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0);
      tbl[5]  = seg("br_latch", LATCH, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0);
      tbl[6]  = seg("d_load0",  1,  1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      tbl[7]  = seg("d_shift0", SH, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
      tbl[8]  = seg("blank0",   1,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      tbl[9]  = seg("d_latch0", LATCH, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
      tbl[10] = seg("switch0",  1,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      tbl[11] = seg("display0", DISP, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      for (int i = 0; i < 12; i++) run_seg(tbl[i]);

      // Steady refresh through layer 15 and wrap to layer 0; brightness
      // request lands mid-display on the wrapped layer 0.
      for (int l = 1; l < NL; l++) do_layer(l, l - 1, 1'b1, -1, -1);
      do_layer(0, NL - 1, 1'b1, 100, -1);
      n_checks++;
      if (fd_seen != 1) begin
         n_fails++;
         $display("FAIL frame_done count: got %0d expected 1", fd_seen);
      end

      // Reload after display; second request during its shift causes one more.
      do_br(1'b1, 1, 0, 10);
      do_layer(1, 0, 1'b0, -1, -1);
      do_br(1'b1, 2, 1, -1);
      do_layer(2, 1, 1'b0, -1, -1);

      // Enable dropped in D_SHIFT: finish display, idle, resume at layer 4.
      do_layer(3, 2, 1'b1, -1, 20);
      s = seg("idle_off", 3, 0, 0, 0, 0, 0, 1, 0, 0, 4, 3);
      run_seg(s);
      s = seg("idle_reen", 1, 0, 0, 0, 0, 0, 1, 0, 0, 4, 3);
      s.en_at = 0;
      run_seg(s);
      do_layer(4, 3, 1'b0, -1, -1);

      // Reset during D_LATCH of layer 5, then brightness reload comes first.
      run_seg(seg("d_load5",  1,  1, 0, 0, 0, 0, 0, 1, 0, 5, 4));
      run_seg(seg("d_shift5", SH, 0, 0, 1, 0, 0, 0, 1, 0, 5, 4));
      run_seg(seg("blank5",   1,  0, 0, 0, 0, 0, 1, 1, 0, 5, 4));
      s = seg("d_latch5_rst", 1, 0, 0, 0, 1, 0, 1, 1, 0, 5, 4);
      s.rst = 1'b1;
      run_seg(s);
      run_seg(seg("post_reset", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      do_br(1'b0, 0, 0, -1);
      do_layer(0, 0, 1'b0, -1, -1);

      n_checks++;
      if (fd_seen != 1) begin
         n_fails++;
         $display("FAIL frame_done total: got %0d expected 1", fd_seen);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
